serial_shifter: RTL and testbench



---
 rtl/serial_shifter.sv | 107 ++++++++++
 tb/tb_serial_shifter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - multi-cycle 16-bit shifter (SLL/SRL/SRA/ROR), one bit per clock
// Start/Done handshake; Busy covers the whole operation including the Done cycle.
module serial_shifter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] hyrja_i,
  input  logic [3:0]  shamt_i,
  input  logic [1:0]  funct_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] result_o,
  output logic        carry_out_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    F_SLL = 2'b00,
    F_SRL = 2'b01,
    F_SRA = 2'b10,
    F_ROR = 2'b11
  } funct_t;

  state_t      state_q, state_d;
  funct_t      funct_q, funct_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;

  logic [15:0] step_result;
  logic        step_carry;

  // Single-position step of the working register for the latched operation.
  always_comb begin
    step_result = result_q;
    step_carry  = result_q[0];
    case (funct_q)
      F_SLL: begin
        step_result = {result_q[14:0], 1'b0};
        step_carry  = result_q[15];
      end
      F_SRL: step_result = {1'b0, result_q[15:1]};
      F_SRA: step_result = {result_q[15], result_q[15:1]};
      F_ROR: step_result = {result_q[0], result_q[15:1]};
      default: step_result = result_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          result_d = hyrja_i;
          cnt_d    = shamt_i;
          funct_d  = funct_t'(funct_i);
          carry_d  = 1'b0;
          state_d  = (shamt_i != 4'd0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        result_d = step_result;
        carry_d  = step_carry;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Start is deliberately ignored here so held-high Start re-arms from IDLE.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      funct_q  <= F_SLL;
      result_q <= 16'h0000;
      cnt_q    <= 4'd0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign result_o    = result_q;
  assign carry_out_o = carry_q;

endmodule

// File: tb/tb_serial_shifter.sv
// tb/tb_serial_shifter.sv - directed + random scoreboard bench for serial_shifter
module tb_serial_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] hyrja;
  logic [3:0]  shamt;
  logic [1:0]  funct;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] r;
    logic        c;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  serial_shifter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .hyrja_i     (hyrja),
    .shamt_i     (shamt),
    .funct_i     (funct),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .carry_out_o (carry)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Closed-form reference, independent of the bit-serial implementation.
  function automatic exp_t model(input logic [15:0] x, input logic [3:0] n, input logic [1:0] f);
    exp_t e;
    int   k;
    k     = int'(n);
    e.lat = k + 1;
    e.c   = (k == 0) ? 1'b0 : x[k-1];
    case (f)
      2'b00: begin
        e.r = x << k;
        e.c = (k == 0) ? 1'b0 : x[16-k];
      end
      2'b01: e.r = x >> k;
      2'b10: e.r = 16'($signed(x) >>> k);
      default: e.r = (x >> k) | (x << (16 - k));
    endcase
    return e;
  endfunction

  task automatic issue(input logic [15:0] x, input logic [3:0] n, input logic [1:0] f,
                       input logic [15:0] er, input logic ec);
    exp_t e;
    e.r   = er;
    e.c   = ec;
    e.lat = int'(n) + 1;
    sb.push_back(e);
    start = 1'b1;
    hyrja = x;
    shamt = n;
    funct = f;
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic finish_op(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (!done && lat < 40) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_lat"}, 32'(lat), 32'(e.lat));
      check({tag, "_result"}, 32'(result), 32'(e.r));
      check({tag, "_carry"}, 32'(carry), 32'(e.c));
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [3:0] n,
                        input logic [1:0] f, input logic [15:0] er, input logic ec);
    issue(x, n, f, er, ec);
    @(negedge clk);
    start = 1'b0;
    hyrja = ~x;
    finish_op(tag);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    exp_t m;
    logic [15:0] rx;
    logic [3:0]  rn;
    logic [1:0]  rf;

    rst   = 1'b1;
    start = 1'b0;
    hyrja = 16'h0;
    shamt = 4'd0;
    funct = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_carry", 32'(carry), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("sll",   16'h0001, 4'd2,  2'b00, 16'h0004, 1'b0);
    run_op("srl",   16'h0400, 4'd6,  2'b01, 16'h0010, 1'b0);
    run_op("sra15", 16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0);
    run_op("sra1",  16'h8001, 4'd1,  2'b10, 16'hC000, 1'b1);
    run_op("ror4",  16'h000F, 4'd4,  2'b11, 16'hF000, 1'b1);
    run_op("ror8",  16'h1234, 4'd8,  2'b11, 16'h3412, 1'b0);
    run_op("sh0",   16'hABCD, 4'd0,  2'b01, 16'hABCD, 1'b0);

    // Start held high; inputs swapped to the second op while busy.
    issue(16'h00F0, 4'd3, 2'b01, 16'h001E, 1'b0);
    @(negedge clk);
    issue(16'h1234, 4'd8, 2'b11, 16'h3412, 1'b0);
    finish_op("hs1");
    @(negedge clk);
    check("hs_gap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("hs_reaccept_busy", 32'(busy), 32'd1);
    start = 1'b0;
    finish_op("hs2");
    @(negedge clk);

    // Reset during an SLL of 10 positions, at cycle 4 of the operation.
    start = 1'b1;
    hyrja = 16'hFFFF;
    shamt = 4'd10;
    funct = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done_pre", 32'(done), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'h0);
    check("abort_carry", 32'(carry), 32'd0);
    rst = 1'b0;
    run_op("post_rst_srl", 16'h8000, 4'd15, 2'b01, 16'h0001, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom);
      rn = 4'($urandom_range(0, 15));
      rf = 2'($urandom_range(0, 3));
      m  = model(rx, rn, rf);
      run_op("rand", rx, rn, rf, m.r, m.c);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
